branch_unit: RTL



---
 rtl/branch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// Execute-stage branch/jump resolver: evaluates the RV32I condition, checks the
// fetch prediction, holds a redirect until fetch takes it, then squashes for FLUSH_CYCLES.
module branch_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_op,
  input  logic            br_jal,
  input  logic            br_jalr,
  input  logic [XLEN-1:0] br_r1,
  input  logic [XLEN-1:0] br_r2,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            br_pred_taken,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            illegal_op,
  output logic [15:0]     br_count,
  output logic [15:0]     mis_count
);

  typedef enum logic [1:0] {S_IDLE, S_REDIR, S_FLUSH} state_t;

  localparam logic [3:0]      FLUSH_N = 4'(FLUSH_CYCLES);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept, eq, lt, ltu, raw, illegal, cond, taken, mispredict;
  logic [XLEN-1:0] seq_pc, br_target, jalr_target, target;

  assign br_ready = resetn & (state_q == S_IDLE);
  assign accept   = br_valid & br_ready;

  // Condition: funct3[2:1] picks the comparator, funct3[0] inverts it
  assign eq  = (br_r1 == br_r2);
  assign lt  = ($signed(br_r1) < $signed(br_r2));
  assign ltu = (br_r1 < br_r2);

  always_comb begin
    raw = 1'b0;
    case (br_op[2:1])
      2'b00:   raw = eq;
      2'b10:   raw = lt;
      2'b11:   raw = ltu;
      default: raw = 1'b0;
    endcase
  end

  assign illegal    = ~br_jal & ~br_jalr & (br_op[2:1] == 2'b01);
  assign cond       = ~illegal & (raw ^ br_op[0]);
  assign taken      = br_jal | br_jalr | cond;
  // Fetch never predicts JALR targets, so every JALR redirects
  assign mispredict = br_jalr | (taken ^ br_pred_taken);

  assign seq_pc      = br_pc + FOUR;
  assign br_target   = br_pc + br_imm;
  assign jalr_target = (br_r1 + br_imm) & ~XLEN'(1);
  assign target      = br_jalr ? jalr_target : br_target;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept && mispredict) state_d = S_REDIR;
      S_REDIR: begin
        if (redir_ready) begin
          if (FLUSH_N == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_N;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q <= 4'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      redir_valid <= 1'b0;
      flush       <= 1'b0;
      redir_pc    <= '0;
      link_valid  <= 1'b0;
      link_data   <= '0;
      illegal_op  <= 1'b0;
      br_count    <= 16'd0;
      mis_count   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      redir_valid <= (state_d == S_REDIR);
      flush       <= (state_d == S_FLUSH);
      link_valid  <= accept & (br_jal | br_jalr);
      illegal_op  <= accept & illegal;
      if (accept && (br_jal || br_jalr)) link_data <= seq_pc;
      if (accept && mispredict) redir_pc <= taken ? target : seq_pc;
      if (accept && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (accept && mispredict && mis_count != 16'hFFFF) mis_count <= mis_count + 16'd1;
    end
  end

endmodule
